// File: rtl/cim_mac_unit_if.sv
// Bundle between the CIM controller and the MAC engine: the start request with
// its operand descriptors, the shared storage read port, and the result return.
interface cim_mac_unit_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 7
);
    logic              start;
    logic [LEN_W-1:0]  len;
    logic [ADDR_W-1:0] in1_addr;
    logic [ADDR_W-1:0] in2_addr;
    logic              in2_is_param;
    logic              bias_en;
    logic [ADDR_W-1:0] bias_addr;
    logic              relu_en;

    logic              mem_rd_en;
    logic              mem_rd_param;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [DATA_W-1:0] mem_rd_data;

    logic              busy;
    logic              done;
    logic [DATA_W-1:0] out;

    // Controller side: issues requests, serves storage reads, collects results.
    modport master (
        output start, len, in1_addr, in2_addr, in2_is_param,
               bias_en, bias_addr, relu_en, mem_rd_data,
        input  mem_rd_en, mem_rd_param, mem_rd_addr, busy, done, out
    );

    // MAC engine side.
    modport slave (
        input  start, len, in1_addr, in2_addr, in2_is_param,
               bias_en, bias_addr, relu_en, mem_rd_data,
        output mem_rd_en, mem_rd_param, mem_rd_addr, busy, done, out
    );
endinterface

// File: rtl/cim_mac_unit.sv
// Fixed-point multiply-accumulate engine sitting behind the CIM controller.
// Streams two operand vectors (and an optional bias) through one shared read
// port, accumulates the dot product at full precision, then rounds, saturates
// and optionally applies ReLU to produce one DATA_W result with a done pulse.
module cim_mac_unit #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 10,
    parameter int ACC_W  = 40,
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 7
) (
    input logic           clk,
    input logic           rst,
    cim_mac_unit_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        BIAS,
        DRAIN,
        OUT
    } state_t;

    // Tags what the read issued last cycle will return this cycle.
    typedef enum logic [1:0] {
        TAG_NONE,
        TAG_OP1,
        TAG_OP2,
        TAG_BIAS
    } rd_tag_t;

    // Half an output LSB, added before the arithmetic shift for round-half-up.
    localparam logic signed [ACC_W:0] HALF_LSB =
        {{(ACC_W + 1 - FRAC_W){1'b0}}, 1'b1, {(FRAC_W - 1){1'b0}}};
    localparam logic signed [ACC_W:0] SAT_MAX =
        {{(ACC_W + 2 - DATA_W){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;
    localparam logic [DATA_W-1:0] OUT_MAX = {1'b0, {(DATA_W - 1){1'b1}}};
    localparam logic [DATA_W-1:0] OUT_MIN = {1'b1, {(DATA_W - 1){1'b0}}};

    state_t                    state_q, state_d;
    rd_tag_t                   rdTag_q, rdTag_d;
    logic [LEN_W-1:0]          elem_q, elem_d;
    logic                      phase_q, phase_d;

    logic [LEN_W-1:0]          len_q;
    logic [ADDR_W-1:0]         in1Base_q;
    logic [ADDR_W-1:0]         in2Base_q;
    logic                      in2Param_q;
    logic                      biasEn_q;
    logic [ADDR_W-1:0]         biasAddr_q;
    logic                      reluEn_q;

    logic                      busy_q;
    logic                      done_q;
    logic [DATA_W-1:0]         out_q;
    logic signed [ACC_W-1:0]   acc_q;
    logic signed [DATA_W-1:0]  op1_q;

    logic                      capture;
    logic                      finish;
    logic                      rdEn;
    logic                      rdParam;
    logic [ADDR_W-1:0]         rdAddr;
    logic                      lastElem;

    logic signed [2*DATA_W-1:0] product;
    logic signed [ACC_W-1:0]    productExt;
    logic signed [ACC_W-1:0]    biasExt;
    logic signed [ACC_W:0]      roundSum;
    logic signed [ACC_W:0]      scaled;
    logic [DATA_W-1:0]          result;

    assign lastElem = (elem_q == (len_q - LEN_W'(1)));

    // Next-state logic and read-port driving; the read port is a pure decode of
    // the current state and counters so reads go out back to back.
    always_comb begin
        state_d = state_q;
        rdTag_d = TAG_NONE;
        elem_d  = elem_q;
        phase_d = phase_q;
        capture = 1'b0;
        finish  = 1'b0;
        rdEn    = 1'b0;
        rdParam = 1'b0;
        rdAddr  = '0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    capture = 1'b1;
                    elem_d  = '0;
                    phase_d = 1'b0;
                    if (bus.len != '0) begin
                        state_d = READ;
                    end else if (bus.bias_en) begin
                        state_d = BIAS;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            READ: begin
                rdEn = 1'b1;
                if (!phase_q) begin
                    rdAddr  = in1Base_q + ADDR_W'(elem_q);
                    rdTag_d = TAG_OP1;
                    phase_d = 1'b1;
                end else begin
                    rdAddr  = in2Base_q + ADDR_W'(elem_q);
                    rdParam = in2Param_q;
                    rdTag_d = TAG_OP2;
                    phase_d = 1'b0;
                    elem_d  = elem_q + LEN_W'(1);
                    if (lastElem) begin
                        state_d = biasEn_q ? BIAS : DRAIN;
                    end
                end
            end
            BIAS: begin
                rdEn    = 1'b1;
                rdParam = 1'b1;
                rdAddr  = biasAddr_q;
                rdTag_d = TAG_BIAS;
                state_d = DRAIN;
            end
            DRAIN: begin
                state_d = OUT;
            end
            OUT: begin
                finish  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, sequencing counters, read tag and the handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rdTag_q <= TAG_NONE;
            elem_q  <= '0;
            phase_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            rdTag_q <= rdTag_d;
            elem_q  <= elem_d;
            phase_q <= phase_d;
            done_q  <= finish;
            if (capture) begin
                busy_q <= 1'b1;
            end
            if (finish) begin
                busy_q <= 1'b0;
                out_q  <= result;
            end
        end
    end

    // Snapshot of the request so the controller may change its inputs freely
    // once the operation has been accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q      <= '0;
            in1Base_q  <= '0;
            in2Base_q  <= '0;
            in2Param_q <= 1'b0;
            biasEn_q   <= 1'b0;
            biasAddr_q <= '0;
            reluEn_q   <= 1'b0;
        end else if (capture) begin
            len_q      <= bus.len;
            in1Base_q  <= bus.in1_addr;
            in2Base_q  <= bus.in2_addr;
            in2Param_q <= bus.in2_is_param;
            biasEn_q   <= bus.bias_en;
            biasAddr_q <= bus.bias_addr;
            reluEn_q   <= bus.relu_en;
        end
    end

    // Full-precision product and bias alignment for the returning data.
    assign product    = op1_q * $signed(bus.mem_rd_data);
    assign productExt = ACC_W'(product);
    assign biasExt    = ACC_W'($signed(bus.mem_rd_data)) <<< FRAC_W;

    // Accumulation: operand 1 is held until its partner arrives, the product
    // and bias are folded in as they land, and the sum is cleared on output.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            op1_q <= '0;
        end else begin
            unique case (rdTag_q)
                TAG_OP1:  op1_q <= $signed(bus.mem_rd_data);
                TAG_OP2:  acc_q <= acc_q + productExt;
                TAG_BIAS: acc_q <= acc_q + biasExt;
                default:  ;
            endcase
            if (finish) begin
                acc_q <= '0;
            end
        end
    end

    // Output scaling: round half up, drop the fraction, saturate, then ReLU.
    assign roundSum = {acc_q[ACC_W-1], acc_q} + HALF_LSB;
    assign scaled   = roundSum >>> FRAC_W;

    // Final result selection from the scaled accumulator.
    always_comb begin
        result = scaled[DATA_W-1:0];
        if (scaled > SAT_MAX) begin
            result = OUT_MAX;
        end else if (scaled < SAT_MIN) begin
            result = OUT_MIN;
        end
        if (reluEn_q && scaled[ACC_W]) begin
            result = '0;
        end
    end

    assign bus.mem_rd_en    = rdEn;
    assign bus.mem_rd_param = rdParam;
    assign bus.mem_rd_addr  = rdAddr;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.out          = out_q;

endmodule
